shift_reg_unit: RTL and testbench

SHIFT_REG_UNIT -- requirements
Module: shift_reg_unit

---
 rtl/shift_reg_unit_pkg.sv | 23 ++
 rtl/shift_reg_unit_shift_step.sv | 24 ++
 rtl/shift_reg_unit.sv | 90 +++++++++
 tb/tb_shift_reg_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_unit_pkg.sv
// Shared encodings for the shift register unit: operation codes and FSM states.
package shift_reg_unit_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SLL) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/shift_reg_unit_shift_step.sv
// Combinational single-bit shift/rotate of the datapath word; unknown ops pass data through.
module shift_step
  import shift_reg_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = {data[DATA_W-2:0], 1'b0};
      OP_SRL:  result = {1'b0, data[DATA_W-1:1]};
      OP_SRA:  result = {data[DATA_W-1], data[DATA_W-1:1]};
      OP_ROR:  result = {data[0], data[DATA_W-1:1]};
      OP_ROL:  result = {data[DATA_W-2:0], data[DATA_W-1]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_reg_unit.sv
// Multi-cycle shift register: LOAD or shift one bit per cycle for shamt cycles.
// Handshake: start is sampled only in IDLE; busy is high for every SHIFT cycle,
// done pulses for one cycle when a LOAD or shift finishes; inputs are ignored otherwise.
module shift_reg_unit
  import shift_reg_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  entry_in,
  input  logic [SHAMT_W-1:0] shamt_in,
  input  logic [2:0]         shift_op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  shift_out,
  output state_t             dbg_state
);

  state_t              state;
  logic [DATA_W-1:0]   sreg;
  logic [SHAMT_W-1:0]  cnt;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   step_val;

  shift_step #(.DATA_W(DATA_W)) u_step (
    .data   (sreg),
    .op     (op_q),
    .result (step_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      op_q  <= OP_NOP;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start && shift_op == OP_LOAD) begin
            sreg  <= entry_in;
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (start && is_shift_op(shift_op)) begin
            op_q <= shift_op;
            cnt  <= shamt_in;
            // A zero shift amount completes at once with the register untouched.
            if (shamt_in != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          sreg <= step_val;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_out = sreg;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Bench for shift_reg_unit: directed scenarios plus random operations against an arithmetic model.
module tb_shift_reg_unit;
  import shift_reg_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] entry_in;
  logic [4:0]  shamt_in;
  logic [2:0]  shift_op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] shift_out;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_reg = '0;

  shift_reg_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .entry_in  (entry_in),
    .shamt_in  (shamt_in),
    .shift_op  (shift_op),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Whole-amount shift computed directly from the operation's definition.
  function automatic logic [31:0] model_shift(input logic [31:0] v, input logic [2:0] op, input int n);
    logic [31:0] r;
    r = v;
    case (op)
      OP_SLL: r = v << n;
      OP_SRL: r = v >> n;
      OP_SRA: r = 32'($signed(v) >>> n);
      OP_ROR: r = (n == 0) ? v : ((v >> n) | (v << (32 - n)));
      OP_ROL: r = (n == 0) ? v : ((v << n) | (v >> (32 - n)));
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] entry, input logic [4:0] shamt,
                        input bit junk_ones);
    int n;
    bit is_load;
    logic [31:0] exp_v;
    entry_in = entry;
    shamt_in = shamt;
    shift_op = op;
    start    = 1'b1;
    is_load  = (op == OP_LOAD);
    @(negedge clk);
    if (!is_load && !is_shift_op(op)) begin
      for (int j = 0; j < 3; j++) begin
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_done", 32'(done), 32'd0);
        check("nop_state", 32'(dbg_state), 32'(ST_IDLE));
        check("nop_data", shift_out, model_reg);
        @(negedge clk);
      end
      start = 1'b0;
      return;
    end
    n = is_load ? 0 : int'(shamt);
    for (int j = 0; j <= n; j++) begin
      check("busy", 32'(busy), 32'(j < n));
      check("done", 32'(done), 32'(j == n));
      check("state", 32'(dbg_state), (j < n) ? 32'(ST_SHIFT) : 32'(ST_DONE));
      exp_v = is_load ? entry : model_shift(model_reg, op, j);
      check("data", shift_out, exp_v);
      // Keep requesting with garbage; it must be ignored while busy and in DONE.
      start    = 1'b1;
      shift_op = junk_ones ? OP_LOAD : 3'($urandom_range(0, 7));
      entry_in = junk_ones ? 32'hFFFF_FFFF : $urandom;
      shamt_in = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    start = 1'b0;
    model_reg = is_load ? entry : model_shift(model_reg, op, n);
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("post_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_data", shift_out, model_reg);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    shift_op = OP_NOP;
    entry_in = '0;
    shamt_in = '0;
    repeat (3) @(negedge clk);
    check("rst_data", shift_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    run_op(OP_LOAD, 32'h8000_00F0, 5'd0, 1'b0);
    run_op(OP_SRA,  32'h0, 5'd4, 1'b0);
    check("sra4", shift_out, 32'hF800_000F);

    run_op(OP_LOAD, 32'h0000_0001, 5'd0, 1'b0);
    run_op(OP_SLL,  32'h0, 5'd31, 1'b0);
    check("sll31", shift_out, 32'h8000_0000);
    run_op(OP_SRL,  32'h0, 5'd31, 1'b0);
    check("srl31", shift_out, 32'h0000_0001);

    run_op(OP_LOAD, 32'h1234_5678, 5'd0, 1'b0);
    run_op(OP_ROR,  32'h0, 5'd0, 1'b0);
    check("ror0", shift_out, 32'h1234_5678);

    run_op(OP_LOAD, 32'h0000_000F, 5'd0, 1'b0);
    run_op(OP_ROR,  32'h0, 5'd4, 1'b1);
    check("ror4", shift_out, 32'hF000_0000);

    run_op(OP_LOAD, 32'h8000_0001, 5'd0, 1'b0);
    run_op(OP_ROL,  32'h0, 5'd1, 1'b0);
    check("rol1", shift_out, 32'h0000_0003);
    run_op(OP_RSVD, 32'hDEAD_BEEF, 5'd3, 1'b0);
    run_op(OP_NOP,  32'hDEAD_BEEF, 5'd3, 1'b0);

    // Abort a shift with reset partway through.
    run_op(OP_LOAD, 32'h0000_00FF, 5'd0, 1'b0);
    shift_op = OP_SLL;
    shamt_in = 5'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_data", shift_out, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("abort_hold_done", 32'(done), 32'd0);
    end
    reset_n   = 1'b1;
    model_reg = '0;
    run_op(OP_LOAD, 32'hA5A5_0001, 5'd0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      run_op(3'($urandom_range(1, 7)), $urandom, 5'($urandom_range(0, 31)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
